spi_target: RTL and testbench
=============================

Name: spi_target

Overview:
- SPI mode-0 target (responder) for the SoC peripheral bus: the opposite end of the SPI initiator on the peripheral pins.
- Lets an external SPI host exchange bytes with tinyQV software.
- Oversamples the asynchronous host SCK/CS/MOSI in the system clock domain.
- Receives MOSI bytes into a one-entry RX holding register; shifts out CPU-loaded bytes on MISO from a one-entry TX buffer.

Parameters:
- DATA_WIDTH, 8, bits per SPI word (RX/TX register width, bit counter wraps at DATA_WIDTH).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rstn  input  1  reset, asynchronous active-low.
- spi_sck_in  input  1  host SPI clock, asynchronous, idles low.
- spi_cs_n_in  input  1  host chip select, asynchronous, active-low.
- spi_mosi_in  input  1  host data in, asynchronous.
- spi_miso  output  1  data to host, MSB first.
- spi_miso_oe  output  1  MISO output enable; high while selected.
- tx_data  input  DATA_WIDTH  byte from CPU for next transmission.
- tx_load  input  1  one-cycle strobe: write tx_data into TX buffer.
- tx_empty  output  1  TX buffer free.
- rx_data  output  DATA_WIDTH  last received byte.
- rx_valid  output  1  rx_data holds an unread byte.
- rx_read  input  1  one-cycle strobe: CPU consumed rx_data.
- rx_overrun  output  1  sticky: a byte was dropped because rx_valid was set.
- clear_overrun  input  1  one-cycle strobe: clears rx_overrun.
- selected  output  1  synchronised CS asserted.
- txn_end  output  1  one-cycle pulse on synchronised CS deassertion.

Behaviour:
- Synchronisation and edge detection:
  - SCK, CS_n and MOSI each pass through a 2-flop synchroniser.
  - SCK and CS_n get a third flop for edge detection; MOSI is sampled from its 2nd sync flop.
  - Edges are acted on 3 clk after the pin transition.
  - Host SCK frequency must be <= clk/8.
- Reset values: spi_miso=0, spi_miso_oe=0, tx_empty=1, rx_data=0, rx_valid=0, rx_overrun=0, selected=0, txn_end=0, bit counter=0, FSM=IDLE. Synchroniser flops reset to the idle pin levels: SCK=0, CS_n=1.
- FSM states:
  - IDLE -> ACTIVE on CS falling edge.
  - ACTIVE -> IDLE on CS rising edge: pulse txn_end for 1 clk and clear the bit counter.
- Start of selection (entering ACTIVE):
  - If tx_empty=0: load the shift-out register from the TX buffer and set tx_empty=1.
  - Otherwise: load all-ones.
  - spi_miso = shift-out MSB; selected=1 and spi_miso_oe=1 from the same cycle.
- SCK rising edge in ACTIVE: shift MOSI into the shift-in register LSB, then increment the bit counter.
  - When the counter wraps from DATA_WIDTH-1 to 0, the word is complete.
  - If rx_valid=0, or rx_read is asserted in the same cycle: rx_data <= new word, rx_valid=1 on the next cycle.
  - Otherwise: drop the word, keep rx_data, set rx_overrun=1.
- SCK falling edge in ACTIVE:
  - If the counter != 0: shift the shift-out register left and present the next bit.
  - If the counter == 0 (word boundary): reload the shift-out register from the TX buffer (tx_empty=1) or all-ones, as at selection start.
- TX buffer:
  - tx_load writes tx_data and sets tx_empty=0.
  - tx_load while tx_empty=0 overwrites the pending byte.
  - tx_load in the same cycle as a reload: the shifter takes the old buffer contents (all-ones if empty), and the new byte stays in the buffer with tx_empty=0.
- RX status strobes:
  - rx_read clears rx_valid next cycle (ignored if already 0).
  - clear_overrun clears rx_overrun. If it coincides with a new overrun, set wins.
- CS deasserted mid-word:
  - Discard the partial word with no rx_valid and no overrun.
  - A shifter loaded from the TX buffer is lost; the TX buffer itself is untouched.
  - spi_miso_oe=0 and spi_miso=0 the same cycle as selected=0.
- SCK edges while in IDLE are ignored.
- rstn asserted mid-transfer: all state returns to reset values immediately (asynchronous).

Test Plan:
- Reset, CS low, host sends 0xA5 at clk/8 -> rx_data=0xA5, rx_valid=1 within 4 clk of the 8th SCK rise; host reads MISO=0xFF; tx_empty stays 1.
- tx_load 0x3C, then the host clocks 2 bytes 0x11,0x22 -> MISO returns 0x3C then 0xFF; tx_empty=1 after CS falls; rx_data=0x11, and the second byte sets rx_overrun=1 if no rx_read was issued.
- Host sends 0x11, rx_read pulsed on the same clk as the 2nd word (0x22) completes -> rx_data=0x22, rx_valid=1, rx_overrun=0.
- CS raised after 5 bits -> no rx_valid, txn_end one-cycle pulse, spi_miso_oe=0; the next full transfer of 0x5A is received correctly (counter restarted).
- tx_load 0x81 issued during the 3rd bit of a transfer -> the current word keeps its shifter contents; the next word on MISO is 0x81.
- rstn asserted mid-word with rx_valid=1, rx_overrun=1, tx_empty=0 -> all outputs at reset values without a clock edge; no rx_valid after rstn releases.

Source files
------------

// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
// Module   : spi_target
// Brief    : SPI mode-0 target. Oversamples host SCK/CS_n/MOSI in the clk
//            domain, receives words into a one-entry RX holding register and
//            shifts CPU-loaded words out on MISO from a one-entry TX buffer.
//            DATA_WIDTH must be at least 2.
// Revision : 1.0 - initial release
// ============================================================================
module spi_target #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  spi_sck_in,
  input  logic                  spi_cs_n_in,
  input  logic                  spi_mosi_in,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_empty,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_read,
  output logic                  rx_overrun,
  input  logic                  clear_overrun,
  output logic                  selected,
  output logic                  txn_end
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0] state;
  logic [0:0] state_nxt;

  // Synchroniser chains; the third SCK/CS_n flop exists only for edge detection.
  logic sck_s1, sck_s2, sck_s3;
  logic cs_s1, cs_s2, cs_s3;
  logic mosi_s1, mosi_s2;

  logic [DATA_WIDTH-1:0] tx_buf;
  logic [DATA_WIDTH-1:0] shift_out;
  logic [DATA_WIDTH-1:0] shift_in;
  logic [DATA_WIDTH-1:0] word_in;
  logic [CNT_W-1:0]      bit_cnt;

  logic sck_rise, sck_fall, cs_fall, cs_rise;
  logic start, stop, act_rise, act_fall, reload, word_done;

  // Bring the asynchronous pins into clk; flops idle at the inactive pin levels.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_s3  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sck_s1  <= spi_sck_in;
      sck_s2  <= sck_s1;
      sck_s3  <= sck_s2;
      cs_s1   <= spi_cs_n_in;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      mosi_s1 <= spi_mosi_in;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sck_rise = sck_s2 & ~sck_s3;
  assign sck_fall = ~sck_s2 & sck_s3;
  assign cs_fall  = ~cs_s2 & cs_s3;
  assign cs_rise  = cs_s2 & ~cs_s3;

  // Deselection takes priority over any SCK edge seen in the same cycle.
  assign start     = (state == ST_IDLE) && cs_fall;
  assign stop      = (state == ST_ACTIVE) && cs_rise;
  assign act_rise  = (state == ST_ACTIVE) && sck_rise && !cs_rise;
  assign act_fall  = (state == ST_ACTIVE) && sck_fall && !cs_rise;
  assign reload    = start || (act_fall && (bit_cnt == '0));
  assign word_done = act_rise && (bit_cnt == CNT_LAST);
  assign word_in   = {shift_in[DATA_WIDTH-2:0], mosi_s2};

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state: follow the synchronised chip select.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cs_fall) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: MISO driven only while selected, MSB of the shifter first.
  always_comb begin
    selected    = (state == ST_ACTIVE);
    spi_miso_oe = selected;
    spi_miso    = selected ? shift_out[DATA_WIDTH-1] : 1'b0;
  end

  // TX buffer: a CPU load always lands in the buffer, even during a reload.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_buf   <= '0;
      tx_empty <= 1'b1;
    end else if (tx_load) begin
      tx_buf   <= tx_data;
      tx_empty <= 1'b0;
    end else if (reload) begin
      tx_empty <= 1'b1;
    end
  end

  // Shift-out register: reload at word boundaries, otherwise shift on SCK fall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_out <= '0;
    end else if (reload) begin
      shift_out <= tx_empty ? '1 : tx_buf;
    end else if (act_fall) begin
      shift_out <= shift_out << 1;
    end
  end

  // Shift-in register and bit counter; a deselect restarts the word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_in <= '0;
      bit_cnt  <= '0;
    end else if (stop) begin
      bit_cnt  <= '0;
    end else if (act_rise) begin
      shift_in <= word_in;
      bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
    end
  end

  // RX holding register and status; a new word or overrun beats a clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (word_done && (!rx_valid || rx_read)) begin
        rx_data  <= word_in;
        rx_valid <= 1'b1;
      end else if (rx_read) begin
        rx_valid <= 1'b0;
      end
      if (word_done && rx_valid && !rx_read) begin
        rx_overrun <= 1'b1;
      end else if (clear_overrun) begin
        rx_overrun <= 1'b0;
      end
    end
  end

  // One-cycle end-of-transaction pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) txn_end <= 1'b0;
    else       txn_end <= stop;
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_target
// Brief    : Randomised and directed bench for spi_target with a host-level
//            reference model and queue-based scoreboards for RX and MISO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_target;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       spi_sck_in = 1'b0;
  logic       spi_cs_n_in = 1'b1;
  logic       spi_mosi_in = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_empty;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_read = 1'b0;
  logic       rx_overrun;
  logic       clear_overrun = 1'b0;
  logic       selected, txn_end;

  spi_target #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn),
    .spi_sck_in(spi_sck_in), .spi_cs_n_in(spi_cs_n_in), .spi_mosi_in(spi_mosi_in),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_load(tx_load), .tx_empty(tx_empty),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_read(rx_read),
    .rx_overrun(rx_overrun), .clear_overrun(clear_overrun),
    .selected(selected), .txn_end(txn_end)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: software-visible state of the peripheral.
  logic       m_tx_pending = 1'b0;
  logic [7:0] m_tx_val = 8'h00;
  logic       m_rx_valid = 1'b0;
  logic       m_overrun = 1'b0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  int         exp_txn = 0;
  int         txn_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // The word the host will see next: the pending CPU byte, or all-ones.
  task automatic model_reload();
    exp_miso.push_back(m_tx_pending ? m_tx_val : 8'hFF);
    m_tx_pending = 1'b0;
  endtask

  task automatic tx_load_pulse(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    m_tx_pending = 1'b1;
    m_tx_val = v;
    wait_clk(1);
    tx_load = 1'b0;
  endtask

  task automatic cpu_read();
    rx_read = 1'b1;
    m_rx_valid = 1'b0;
    wait_clk(1);
    rx_read = 1'b0;
    wait_clk(1);
  endtask

  task automatic clear_ov();
    clear_overrun = 1'b1;
    m_overrun = 1'b0;
    wait_clk(1);
    clear_overrun = 1'b0;
    wait_clk(1);
  endtask

  task automatic cs_low();
    model_reload();
    spi_cs_n_in = 1'b0;
    wait_clk(6);
    check("selected_on", selected, 1'b1);
    check("miso_oe_on", spi_miso_oe, 1'b1);
    check("tx_empty_after_start", tx_empty, 1'b1);
  endtask

  task automatic cs_high();
    spi_cs_n_in = 1'b1;
    exp_txn++;
    wait_clk(5);
    check("selected_off", selected, 1'b0);
    check("miso_oe_off", spi_miso_oe, 1'b0);
    check("miso_off", spi_miso, 1'b0);
    check("txn_end_pulses", txn_seen, exp_txn);
    check("tx_empty_after_txn", tx_empty, !m_tx_pending);
    // The word in flight at deselect never completes on the host side.
    if (exp_miso.size() > 0) void'(exp_miso.pop_back());
  endtask

  // Host clocks nbits of w MSB first at clk/8. rd pulses rx_read on the exact
  // cycle the 8th bit completes; ldbit (>=0) issues a tx_load during that bit.
  task automatic send_word(input logic [7:0] w, input int nbits, input logic rd,
                           input int ldbit, input logic [7:0] ldval);
    for (int k = 0; k < nbits; k++) begin
      spi_mosi_in = w[7-k];
      wait_clk(4);
      spi_sck_in = 1'b1;
      if (nbits == 8 && k == 7) begin
        if (!m_rx_valid || rd) begin
          exp_rx.push_back(w);
          m_rx_valid = 1'b1;
        end else begin
          m_overrun = 1'b1;
        end
      end
      wait_clk(2);
      if (rd && k == 7) begin
        rx_read = 1'b1;
        wait_clk(1);
        rx_read = 1'b0;
      end else if (k == ldbit) begin
        tx_load_pulse(ldval);
      end else begin
        wait_clk(1);
      end
      wait_clk(1);
      spi_sck_in = 1'b0;
    end
    wait_clk(4);
    if (nbits == 8) begin
      check("rx_valid_after_word", rx_valid, m_rx_valid);
      check("overrun_after_word", rx_overrun, m_overrun);
      model_reload();
    end
  endtask

  // RX monitor: a newly presented word is compared against the scoreboard.
  logic       pv = 1'b0;
  logic [7:0] pd = 8'h00;
  always @(negedge clk) begin
    if (!rstn) begin
      pv = 1'b0;
      pd = 8'h00;
    end else begin
      if (rx_valid && (!pv || rx_data != pd)) begin
        checks++;
        if (exp_rx.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: got %0h, expected no word", rx_data);
        end else begin
          logic [7:0] e;
          e = exp_rx.pop_front();
          if (rx_data !== e) begin
            errors++;
            $display("FAIL rx_data: got %0h, expected %0h", rx_data, e);
          end
        end
      end
      pv = rx_valid;
      pd = rx_data;
    end
  end

  // MISO monitor: the host samples on SCK rise; full words go to the scoreboard.
  int         mbits = 0;
  logic [7:0] mword = 8'h00;
  always @(posedge spi_sck_in or negedge spi_cs_n_in) begin
    if (spi_sck_in && !spi_cs_n_in) begin
      mword = {mword[6:0], spi_miso};
      mbits++;
      if (mbits == 8) begin
        mbits = 0;
        checks++;
        if (exp_miso.size() == 0) begin
          errors++;
          $display("FAIL miso_unexpected: got %0h, expected no word", mword);
        end else begin
          logic [7:0] e;
          e = exp_miso.pop_front();
          if (mword !== e) begin
            errors++;
            $display("FAIL miso_word: got %0h, expected %0h", mword, e);
          end
        end
      end
    end else begin
      mbits = 0;
    end
  end

  // Count txn_end high cycles; a stretched pulse shows up as an extra count.
  always @(negedge clk) if (rstn && txn_end) txn_seen++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clk(3);
    check("rst_miso", spi_miso, 1'b0);
    check("rst_miso_oe", spi_miso_oe, 1'b0);
    check("rst_tx_empty", tx_empty, 1'b1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_overrun", rx_overrun, 1'b0);
    check("rst_selected", selected, 1'b0);
    check("rst_txn_end", txn_end, 1'b0);
    rstn = 1'b1;
    wait_clk(5);

    // Plain receive with an empty TX buffer.
    cs_low();
    send_word(8'hA5, 8, 1'b0, -1, 8'h00);
    cs_high();
    check("t1_rx_data", rx_data, 8'hA5);
    cpu_read();
    check("t1_rx_valid_cleared", rx_valid, 1'b0);

    // Loaded byte then all-ones; second word overruns.
    tx_load_pulse(8'h3C);
    check("t2_tx_empty_loaded", tx_empty, 1'b0);
    cs_low();
    send_word(8'h11, 8, 1'b0, -1, 8'h00);
    send_word(8'h22, 8, 1'b0, -1, 8'h00);
    cs_high();
    check("t2_rx_data", rx_data, 8'h11);
    check("t2_overrun", rx_overrun, 1'b1);
    clear_ov();
    check("t2_overrun_cleared", rx_overrun, 1'b0);
    cpu_read();

    // Read coinciding with completion of the second word.
    cs_low();
    send_word(8'h11, 8, 1'b0, -1, 8'h00);
    send_word(8'h22, 8, 1'b1, -1, 8'h00);
    cs_high();
    check("t3_rx_data", rx_data, 8'h22);
    check("t3_rx_valid", rx_valid, 1'b1);
    check("t3_overrun", rx_overrun, 1'b0);
    cpu_read();

    // Abort after 5 bits, then a full word must align from bit 0.
    cs_low();
    send_word(8'hF0, 5, 1'b0, -1, 8'h00);
    cs_high();
    check("t4_no_rx_valid", rx_valid, 1'b0);
    check("t4_no_overrun", rx_overrun, 1'b0);
    cs_low();
    send_word(8'h5A, 8, 1'b0, -1, 8'h00);
    cs_high();
    check("t4_rx_data", rx_data, 8'h5A);
    cpu_read();

    // Load during the 3rd bit: current word unaffected, next word carries it.
    cs_low();
    send_word(8'h33, 8, 1'b0, 2, 8'h81);
    send_word(8'h44, 8, 1'b0, -1, 8'h00);
    cs_high();
    cpu_read();
    clear_ov();

    // SCK activity while deselected is ignored.
    for (int i = 0; i < 8; i++) begin
      spi_sck_in = 1'b1;
      wait_clk(4);
      spi_sck_in = 1'b0;
      wait_clk(4);
    end
    check("t6_idle_rx_valid", rx_valid, 1'b0);
    check("t6_idle_selected", selected, 1'b0);
    cs_low();
    send_word(8'h96, 8, 1'b0, -1, 8'h00);
    cs_high();
    check("t6_rx_data", rx_data, 8'h96);
    cpu_read();

    // Randomised transactions.
    for (int t = 0; t < 24; t++) begin
      int nw;
      if ($urandom_range(1, 0) == 1) tx_load_pulse(8'($urandom));
      cs_low();
      nw = $urandom_range(3, 1);
      for (int j = 0; j < nw; j++) begin
        int   nb;
        int   ld;
        logic rd;
        nb = (j == nw - 1 && $urandom_range(3, 0) == 0) ? $urandom_range(7, 1) : 8;
        ld = ($urandom_range(3, 0) == 0) ? $urandom_range(nb - 1, 0) : -1;
        rd = (nb == 8) && ($urandom_range(3, 0) == 0);
        send_word(8'($urandom), nb, rd, ld, 8'($urandom));
        if (nb == 8 && $urandom_range(1, 0) == 1) cpu_read();
      end
      cs_high();
      check("rnd_overrun", rx_overrun, m_overrun);
      check("rnd_rx_valid", rx_valid, m_rx_valid);
      if ($urandom_range(1, 0) == 1) clear_ov();
      if ($urandom_range(1, 0) == 1) cpu_read();
    end

    // Asynchronous reset in the middle of a word with all status set.
    cs_low();
    send_word(8'h12, 8, 1'b0, -1, 8'h00);
    send_word(8'h34, 8, 1'b0, -1, 8'h00);
    tx_load_pulse(8'h77);
    send_word(8'h55, 3, 1'b0, -1, 8'h00);
    check("t7_pre_overrun", rx_overrun, 1'b1);
    check("t7_pre_tx_empty", tx_empty, 1'b0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("arst_miso", spi_miso, 1'b0);
    check("arst_miso_oe", spi_miso_oe, 1'b0);
    check("arst_tx_empty", tx_empty, 1'b1);
    check("arst_rx_data", rx_data, 8'h00);
    check("arst_rx_valid", rx_valid, 1'b0);
    check("arst_overrun", rx_overrun, 1'b0);
    check("arst_selected", selected, 1'b0);
    check("arst_txn_end", txn_end, 1'b0);
    spi_cs_n_in = 1'b1;
    spi_sck_in = 1'b0;
    spi_mosi_in = 1'b0;
    m_tx_pending = 1'b0;
    m_rx_valid = 1'b0;
    m_overrun = 1'b0;
    exp_rx.delete();
    exp_miso.delete();
    wait_clk(3);
    rstn = 1'b1;
    wait_clk(10);
    check("post_rst_rx_valid", rx_valid, 1'b0);
    check("post_rst_selected", selected, 1'b0);
    check("post_rst_tx_empty", tx_empty, 1'b1);
    check("post_rst_txn_end", txn_seen, exp_txn);

    check("rx_queue_drained", exp_rx.size(), 0);
    check("miso_queue_drained", exp_miso.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
